ctrl_ramdrv_seq: RTL and testbench

CTRL_RAMDRV_SEQ -- requirements
Module: ctrl_ramdrv_seq

---
 rtl/ctrl_ramdrv_seq_if.sv | 35 +++
 rtl/ctrl_ramdrv_seq.sv | 136 +++++++++++++
 tb/tb_ctrl_ramdrv_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_ramdrv_seq_if.sv
// Handshake/bus bundle for the coefficient RAM driver sequencer.
//   master : sample-rate side + CPU side (drives start/phase/taps, cpu_req/cpu_addr)
//   slave  : the sequencer (drives counter controls, MAC controls, status)
interface ctrl_ramdrv_seq_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int TAP_WIDTH   = 8,
  parameter int PHASE_WIDTH = 4
);
  logic                   start;
  logic [PHASE_WIDTH-1:0] phase;
  logic [TAP_WIDTH-1:0]   taps;
  logic                   cpu_req;
  logic [ADDR_WIDTH-1:0]  cpu_addr;
  logic                   coef_load;
  logic                   coef_cnt;
  logic [ADDR_WIDTH-1:0]  coef_ptr;
  logic                   mac_clr;
  logic                   mac_en;
  logic                   out_valid;
  logic                   busy;
  logic                   cpu_ack;
  logic                   overrun;

  modport master (
    output start, phase, taps, cpu_req, cpu_addr,
    input  coef_load, coef_cnt, coef_ptr, mac_clr, mac_en,
           out_valid, busy, cpu_ack, overrun
  );

  modport slave (
    input  start, phase, taps, cpu_req, cpu_addr,
    output coef_load, coef_cnt, coef_ptr, mac_clr, mac_en,
           out_valid, busy, cpu_ack, overrun
  );
endinterface

// File: rtl/ctrl_ramdrv_seq.sv
// Polyphase FIR coefficient RAM driver sequencer.
// One start runs LOAD -> MAC x taps -> FLUSH -> DONE, steering an external
// coefficient address counter and accumulator. Idle cycles can serve a CPU
// pointer load (CPU_WR). All outputs are flops whose next value is decoded
// from the next state, so each output is aligned with the state it belongs to.
// Ports:
//   clk   : clock, rising edge
//   clr_n : async active-low reset, forces IDLE and all outputs to 0
//   bus   : ctrl_ramdrv_seq_if.slave (start/phase/taps, cpu_req/cpu_addr in;
//           coef_load/coef_cnt/coef_ptr, mac_clr/mac_en, out_valid, busy,
//           cpu_ack, overrun out)
module ctrl_ramdrv_seq #(
  parameter int ADDR_WIDTH  = 12,
  parameter int TAP_WIDTH   = 8,
  parameter int PHASE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  ctrl_ramdrv_seq_if.slave      bus
);
  localparam int PW = PHASE_WIDTH + TAP_WIDTH;
  localparam int MW = (PW > ADDR_WIDTH) ? PW : ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, FLUSH, DONE, CPU_WR} state_t;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [TAP_WIDTH-1:0]   taps_q, taps_d, tap_cnt_q, tap_cnt_d;
  logic [ADDR_WIDTH-1:0]  cpu_addr_q, cpu_addr_d;
  logic [MW-1:0]          prod;

  logic                  coef_load_q, coef_load_d, coef_cnt_q, coef_cnt_d;
  logic [ADDR_WIDTH-1:0] coef_ptr_q, coef_ptr_d;
  logic                  mac_clr_q, mac_clr_d, mac_en_q, mac_en_d;
  logic                  out_valid_q, out_valid_d, busy_q, busy_d;
  logic                  cpu_ack_q, cpu_ack_d, overrun_q, overrun_d;

  // Next-state, captured operands and tap down-counter
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    taps_d     = taps_q;
    cpu_addr_d = cpu_addr_q;
    tap_cnt_d  = tap_cnt_q;
    case (state_q)
      IDLE: begin
        // start wins over a simultaneous cpu_req; the CPU is served later
        if (bus.start) begin
          phase_d = bus.phase;
          taps_d  = bus.taps;
          state_d = LOAD;
        end else if (bus.cpu_req) begin
          cpu_addr_d = bus.cpu_addr;
          state_d    = CPU_WR;
        end
      end
      LOAD: begin
        if (taps_q != '0) begin
          tap_cnt_d = taps_q - TAP_WIDTH'(1);
          state_d   = MAC;
        end else begin
          state_d = DONE;
        end
      end
      MAC: begin
        if (tap_cnt_q == '0) state_d = FLUSH;
        else                 tap_cnt_d = tap_cnt_q - TAP_WIDTH'(1);
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      CPU_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, decoded from the state being entered
  always_comb begin
    prod        = MW'(phase_d) * MW'(taps_d);
    coef_load_d = (state_d == LOAD) || (state_d == CPU_WR);
    coef_cnt_d  = (state_d == MAC);
    coef_ptr_d  = '0;
    if (state_d == LOAD)   coef_ptr_d = prod[ADDR_WIDTH-1:0];
    if (state_d == CPU_WR) coef_ptr_d = cpu_addr_d;
    mac_clr_d   = (state_d == LOAD);
    // RAM data arrives one cycle after the address advances
    mac_en_d    = coef_cnt_q;
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    cpu_ack_d   = (state_d == CPU_WR);
    overrun_d   = bus.start && (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      taps_q      <= '0;
      cpu_addr_q  <= '0;
      tap_cnt_q   <= '0;
      coef_load_q <= 1'b0;
      coef_cnt_q  <= 1'b0;
      coef_ptr_q  <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      taps_q      <= taps_d;
      cpu_addr_q  <= cpu_addr_d;
      tap_cnt_q   <= tap_cnt_d;
      coef_load_q <= coef_load_d;
      coef_cnt_q  <= coef_cnt_d;
      coef_ptr_q  <= coef_ptr_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cpu_ack_q   <= cpu_ack_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.coef_load = coef_load_q;
  assign bus.coef_cnt  = coef_cnt_q;
  assign bus.coef_ptr  = coef_ptr_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_ctrl_ramdrv_seq.sv
// Scoreboard bench for ctrl_ramdrv_seq. Stimulus pushes expected events
// (pointer loads, run completions, CPU acks, overruns) with the cycle they are
// due; a negedge monitor pops and compares them as the DUT produces them.
// Latency is counted inclusively of the start cycle: a start seen in cycle c
// shows coef_load in c+1 and out_valid in c+taps+3 (c+2 for taps=0).
module tb_ctrl_ramdrv_seq;
  localparam int AW = 12, TW = 8, PW = 4;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  typedef struct {int cyc; int val;} ev_t;
  ev_t ld_q[$], run_q[$], ack_q[$], ovr_q[$];

  ctrl_ramdrv_seq_if #(.ADDR_WIDTH(AW), .TAP_WIDTH(TW), .PHASE_WIDTH(PW)) bus();

  ctrl_ramdrv_seq #(.ADDR_WIDTH(AW), .TAP_WIDTH(TW), .PHASE_WIDTH(PW)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor
  logic prev_cnt = 1'b0;
  int   n_cnt = 0, n_mac = 0;
  ev_t  e;

  always @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev_cnt <= 1'b0;
      n_cnt    <= 0;
      n_mac    <= 0;
    end else begin
      chk("load_cnt_excl", 64'(bus.coef_load & bus.coef_cnt), 0);
      if (!bus.coef_load) chk("ptr_zero", 64'(bus.coef_ptr), 0);
      chk("mac_en_lag", 64'(bus.mac_en), 64'(prev_cnt));
      prev_cnt <= bus.coef_cnt;
      if (bus.coef_cnt) n_cnt <= n_cnt + 1;
      if (bus.mac_en)   n_mac <= n_mac + 1;
      if (bus.coef_load) begin
        if (ld_q.size() == 0) chk("load_unexpected", 1, 0);
        else begin
          e = ld_q.pop_front();
          chk("load_cyc", cyc, e.cyc);
          chk("load_ptr", 64'(bus.coef_ptr), e.val);
          chk("mac_clr", 64'(bus.mac_clr), 64'(!bus.cpu_ack));
        end
        n_cnt <= 0;
        n_mac <= 0;
      end
      if (bus.out_valid) begin
        if (run_q.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          e = run_q.pop_front();
          chk("out_cyc", cyc, e.cyc);
          chk("cnt_cycles", n_cnt, e.val);
          chk("mac_cycles", n_mac, e.val);
          chk("busy_at_done", 64'(bus.busy), 1);
        end
      end
      if (bus.cpu_ack) begin
        if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          e = ack_q.pop_front();
          chk("ack_cyc", cyc, e.cyc);
        end
      end
      if (bus.overrun) begin
        if (ovr_q.size() == 0) chk("ovr_unexpected", 1, 0);
        else begin
          e = ovr_q.pop_front();
          chk("ovr_cyc", cyc, e.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] outs();
    return 32'({bus.coef_load, bus.coef_cnt, bus.coef_ptr, bus.mac_clr, bus.mac_en,
                bus.out_valid, bus.busy, bus.cpu_ack, bus.overrun});
  endfunction

  // Called at a negedge; pulses start for one cycle and queues what it must produce
  task automatic do_start(input int p, input int t, output int c);
    c = cyc;
    bus.phase = PW'(p);
    bus.taps  = TW'(t);
    bus.start = 1'b1;
    ld_q.push_back('{c + 1, (p * t) % (1 << AW)});
    run_q.push_back('{c + ((t != 0) ? t + 4 : 3) - 1, t});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_ack();
    int i;
    for (i = 0; i < 50; i++) begin
      if (bus.cpu_ack) break;
      @(negedge clk);
    end
    chk("ack_timeout", (i < 50) ? 1 : 0, 1);
    bus.cpu_req = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 600; i++) begin
      if (ld_q.size() + run_q.size() + ack_q.size() + ovr_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain", ld_q.size() + run_q.size() + ack_q.size() + ovr_q.size(), 0);
  endtask

  task automatic run_basic();
    int c;
    do_start(3, 5, c);
    while (cyc < c + 9) @(negedge clk);
    chk("busy_after_done", 64'(bus.busy), 0);
    drain();
  endtask

  initial begin
    int c;
    bus.start = 1'b0; bus.phase = '0; bus.taps = '0;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0;
    #3 chk("reset_outs", 64'(outs()), 0);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", 64'(outs()), 0);

    // phase 3, taps 5: ptr 15, 5 count cycles, mac_en lagging, done at c+8
    run_basic();

    // start and cpu_req together: run first, CPU write after returning to IDLE
    bus.cpu_req = 1'b1; bus.cpu_addr = AW'(12'h123);
    do_start(1, 3, c);
    ld_q.push_back('{c + 8, 'h123});
    ack_q.push_back('{c + 8, 0});
    wait_ack();
    drain();

    // standalone CPU write
    c = cyc;
    bus.cpu_req = 1'b1; bus.cpu_addr = AW'(12'hABC);
    ld_q.push_back('{c + 1, 'hABC});
    ack_q.push_back('{c + 1, 0});
    @(negedge clk);
    wait_ack();
    drain();

    // second start during MAC is dropped with a single overrun pulse
    do_start(2, 6, c);
    @(negedge clk); @(negedge clk);
    bus.phase = PW'(9); bus.taps = TW'(1); bus.start = 1'b1;
    ovr_q.push_back('{cyc + 1, 0});
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // taps 0: pointer 0, no counting, done two cycles after the start cycle
    do_start(7, 0, c);
    drain();

    // async reset mid-MAC aborts the run; outputs clear without a clock edge
    do_start(4, 6, c);
    @(negedge clk); @(negedge clk);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1 chk("async_reset_outs", 64'(outs()), 0);
    run_q.delete();
    ld_q.delete();
    #1 clr_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_out", run_q.size(), 0);
    run_basic();

    // largest phase and tap count: ptr 3825, 255 count cycles
    do_start(15, 255, c);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
